// File: rtl/ooo_branch_resolver.sv
// ooo_branch_resolver: ROB-keyed branch table that turns in-order commits into resolve/flush pulses for the predictor (BR_RESOLVE_STATS_EN adds pulse counters)
module ooo_branch_resolver #(
    parameter int ROB_WIDTH      = 4,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dispatch_en,
    input  logic [ROB_WIDTH-1:0] dispatch_rob_id,
    input  logic                 dispatch_is_br,
    input  logic [31:0]          dispatch_pc,
    input  logic                 dispatch_pred_taken,
    input  logic [31:0]          dispatch_pred_target,
    input  logic                 ex_valid,
    input  logic [ROB_WIDTH-1:0] ex_rob_id,
    input  logic                 ex_taken,
    input  logic [31:0]          ex_target,
    input  logic                 commit_en,
    input  logic [ROB_WIDTH-1:0] commit_rob_id,
    output logic                 commit_stall,
    output logic                 resolve_en,
    output logic                 mispredict,
    output logic [ROB_WIDTH-1:0] resolve_rob_id,
    output logic [31:0]          actual_target,
`ifdef BR_RESOLVE_STATS_EN
    output logic [31:0]          stat_branches,
    output logic [31:0]          stat_mispredicts,
`endif
    output logic                 busy
);
    localparam int ROB_SIZE = 2**ROB_WIDTH;
    typedef enum logic [1:0] {RUN, FLUSH, RECOVER} state_t;
    state_t state_q;
    logic [3:0] cnt_q;
    logic [ROB_SIZE-1:0] valid_q, done_q, is_br_q, pred_taken_q, act_taken_q;
    logic [31:0] pc_q [ROB_SIZE];
    logic [31:0] pred_target_q [ROB_SIZE];
    logic [31:0] act_target_q [ROB_SIZE];
    logic run, bypass, commit_ok, br_commit, ex_ok, c_taken, c_mis;
    logic [31:0] c_target, c_next;
    // Head lookup: a same-cycle execute result stands in for a missing stored outcome
    always_comb begin
        run          = state_q == RUN;
        bypass       = ex_valid && ex_rob_id == commit_rob_id;
        commit_stall = run & commit_en & valid_q[commit_rob_id] & is_br_q[commit_rob_id] & ~done_q[commit_rob_id] & ~bypass;
        commit_ok    = run & commit_en & ~commit_stall;
        br_commit    = commit_ok & valid_q[commit_rob_id] & is_br_q[commit_rob_id];
        c_taken      = done_q[commit_rob_id] ? act_taken_q[commit_rob_id] : ex_taken;
        c_target     = done_q[commit_rob_id] ? act_target_q[commit_rob_id] : ex_target;
        c_next       = c_taken ? c_target : pc_q[commit_rob_id] + 32'd4;
        c_mis        = (pred_taken_q[commit_rob_id] != c_taken) | (c_taken & (pred_target_q[commit_rob_id] != c_target));
        ex_ok        = run & ex_valid & valid_q[ex_rob_id] & is_br_q[ex_rob_id] & ~done_q[ex_rob_id];
        busy         = ~run;
    end
    // Entry status bits: execute marks done, commit frees, dispatch (last, so it wins) allocates; flush wipes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            done_q  <= '0;
        end else if (state_q == FLUSH) begin
            valid_q <= '0;
            done_q  <= '0;
        end else if (run) begin
            if (ex_ok) done_q[ex_rob_id] <= 1'b1;
            if (commit_ok) valid_q[commit_rob_id] <= 1'b0;
            if (dispatch_en) begin
                valid_q[dispatch_rob_id] <= 1'b1;
                done_q[dispatch_rob_id]  <= 1'b0;
            end
        end
    end
    // Entry payload: only meaningful while the status bits say so, hence no reset
    always_ff @(posedge clk) begin
        if (ex_ok) begin
            act_taken_q[ex_rob_id]  <= ex_taken;
            act_target_q[ex_rob_id] <= ex_target;
        end
        if (run && dispatch_en) begin
            is_br_q[dispatch_rob_id]       <= dispatch_is_br;
            pc_q[dispatch_rob_id]          <= dispatch_pc;
            pred_taken_q[dispatch_rob_id]  <= dispatch_pred_taken;
            pred_target_q[dispatch_rob_id] <= dispatch_pred_target;
        end
    end
    // Resolve pulse registers and the flush/recover sequencer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            resolve_en     <= 1'b0;
            mispredict     <= 1'b0;
            resolve_rob_id <= '0;
            actual_target  <= '0;
        end else begin
            resolve_en <= br_commit;
            mispredict <= br_commit & c_mis;
            if (br_commit) begin
                resolve_rob_id <= commit_rob_id;
                actual_target  <= c_next;
            end
            case (state_q)
                RUN:     if (br_commit && c_mis) state_q <= FLUSH;
                FLUSH: begin
                    state_q <= RECOVER;
                    cnt_q   <= 4'(RECOVER_CYCLES - 1);
                end
                RECOVER: if (cnt_q == '0) state_q <= RUN; else cnt_q <= cnt_q - 4'd1;
                default: state_q <= RUN;
            endcase
        end
    end
`ifdef BR_RESOLVE_STATS_EN
    // Saturating counts of resolve and mispredict pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (br_commit) begin
            if (stat_branches != '1) stat_branches <= stat_branches + 32'd1;
            if (c_mis && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif
endmodule
